// File: rtl/rnn_decoder.sv
// Difference decoder: recovers current[t] = state[t] - state[t-1] (mod 256) into a small output FIFO.
// Optional statistics outputs (sample_cnt, wrap_flag) are built when RNN_DECODER_STATS_EN is defined.
module rnn_decoder #(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_state,
   input  logic       in_first,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_current
`ifdef RNN_DECODER_STATS_EN
   ,
   output logic [15:0] sample_cnt,
   output logic        wrap_flag
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [0:0] {StIdle, StRun} phase_e;

   phase_e          phase_q, phase_d;
   logic [7:0]      prev_q, prev_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            in_ready_q, out_valid_q;
   logic [7:0]      out_q, out_d;
   logic            push, pop;
   logic [7:0]      prev_eff, diff;

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_current = out_q;

   // clr overrides both handshakes on the same edge
   assign push     = in_valid & in_ready_q & ~clr;
   assign pop      = out_valid_q & out_ready & ~clr;
   assign prev_eff = (in_first || phase_q == StIdle) ? 8'h00 : prev_q;
   assign diff     = in_state - prev_eff;

   always_comb begin
      phase_d = phase_q;
      prev_d  = prev_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (clr) begin
         phase_d = StIdle;
         prev_d  = 8'h00;
         rd_d    = '0;
         wr_d    = '0;
         cnt_d   = '0;
      end else begin
         if (push) begin
            phase_d = StRun;
            prev_d  = in_state;
            wr_d    = wr_q + 1'b1;
         end
         if (pop) rd_d = rd_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Next head is either already stored or being written on this very edge
   always_comb begin
      out_d = 8'h00;
      if (cnt_d != '0) begin
         if (push && wr_q == rd_d) out_d = diff;
         else                      out_d = mem_q[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= diff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= StIdle;
         prev_q      <= 8'h00;
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= 8'h00;
      end else begin
         phase_q     <= phase_d;
         prev_q      <= prev_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= (cnt_d < CW'(DEPTH));
         out_valid_q <= (cnt_d != '0);
         out_q       <= out_d;
      end
   end

`ifdef RNN_DECODER_STATS_EN
   logic [15:0] sample_cnt_q;
   logic        wrap_q;

   assign sample_cnt = sample_cnt_q;
   assign wrap_flag  = wrap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_cnt_q <= 16'h0000;
         wrap_q       <= 1'b0;
      end else if (clr) begin
         sample_cnt_q <= 16'h0000;
         wrap_q       <= 1'b0;
      end else if (push) begin
         if (sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 16'h0001;
         if (phase_q == StRun && !in_first && in_state < prev_q) wrap_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rnn_decoder.sv
// Directed bench for rnn_decoder (DEPTH=2); inputs change and outputs are checked on falling edges.
module tb_rnn_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_state = 8'h00;
   logic       in_first = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_current;
`ifdef RNN_DECODER_STATS_EN
   logic [15:0] sample_cnt;
   logic        wrap_flag;
`endif

   int nvec = 0;
   int nerr = 0;

   rnn_decoder #(.DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .in_first    (in_first),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_current (out_current)
`ifdef RNN_DECODER_STATS_EN
      ,
      .sample_cnt  (sample_cnt),
      .wrap_flag   (wrap_flag)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] s, input logic f);
      in_valid = v;
      in_state = s;
      in_first = f;
   endtask

   initial begin
      // reset
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 16'(in_ready), 16'd0);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_out_current", 16'(out_current), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", 16'(in_ready), 16'd1);

      // basic stream 3, 8, 2 -> 3, 5, 250
      out_ready = 1'b1;
      drive(1'b1, 8'd3, 1'b1);
      @(negedge clk);
      check("basic0_valid", 16'(out_valid), 16'd1);
      check("basic0", 16'(out_current), 16'd3);
      drive(1'b1, 8'd8, 1'b0);
      @(negedge clk);
      check("basic1", 16'(out_current), 16'd5);
      drive(1'b1, 8'd2, 1'b0);
      @(negedge clk);
      check("basic2_wrap", 16'(out_current), 16'd250);
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clk);
      check("basic_drained", 16'(out_valid), 16'd0);

      // backpressure 10, 20, 30 with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 8'd10, 1'b1);
      @(negedge clk);
      check("bp_ready_one", 16'(in_ready), 16'd1);
      drive(1'b1, 8'd20, 1'b0);
      @(negedge clk);
      check("bp_ready_full", 16'(in_ready), 16'd0);
      check("bp_head", 16'(out_current), 16'd10);
      drive(1'b1, 8'd30, 1'b0);
      @(negedge clk);
      check("bp_still_full", 16'(in_ready), 16'd0);
      check("bp_head_stable", 16'(out_current), 16'd10);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_pop1", 16'(out_current), 16'd10);
      check("bp_ready_back", 16'(in_ready), 16'd1);
      @(negedge clk);
      check("bp_pop2_valid", 16'(out_valid), 16'd1);
      check("bp_pop2", 16'(out_current), 16'd10);
      check("bp_pushpop_ready", 16'(in_ready), 16'd1);
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clk);
      check("bp_drained", 16'(out_valid), 16'd0);

      // mid-stream restart 5, 9, 7(first) -> 5, 4, 7
      drive(1'b1, 8'd5, 1'b1);
      @(negedge clk);
      check("restart0", 16'(out_current), 16'd5);
      drive(1'b1, 8'd9, 1'b0);
      @(negedge clk);
      check("restart1", 16'(out_current), 16'd4);
      drive(1'b1, 8'd7, 1'b1);
      @(negedge clk);
      check("restart2", 16'(out_current), 16'd7);
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clk);

      // clr with concurrent input: sample dropped, history cleared
      out_ready = 1'b0;
      drive(1'b1, 8'd40, 1'b1);
      @(negedge clk);
      check("clr_pre_valid", 16'(out_valid), 16'd1);
      clr = 1'b1;
      drive(1'b1, 8'd99, 1'b0);
      @(negedge clk);
      clr = 1'b0;
      check("clr_empty", 16'(out_valid), 16'd0);
      check("clr_current", 16'(out_current), 16'd0);
      drive(1'b1, 8'd6, 1'b0);
      @(negedge clk);
      check("clr_next6", 16'(out_current), 16'd6);
      out_ready = 1'b1;
      drive(1'b1, 8'd9, 1'b0);
      @(negedge clk);
      check("same_edge_valid", 16'(out_valid), 16'd1);
      check("same_edge_val", 16'(out_current), 16'd3);
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clk);
      check("same_edge_drained", 16'(out_valid), 16'd0);

      // async reset with two entries queued
      out_ready = 1'b0;
      drive(1'b1, 8'd50, 1'b1);
      @(negedge clk);
      drive(1'b1, 8'd60, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0);
      check("ar_pre_full", 16'(in_ready), 16'd0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 16'(out_valid), 16'd0);
      check("ar_current", 16'(out_current), 16'd0);
      check("ar_in_ready", 16'(in_ready), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("ar_in_ready_back", 16'(in_ready), 16'd1);
      check("ar_no_stale", 16'(out_valid), 16'd0);
      out_ready = 1'b1;
      drive(1'b1, 8'd7, 1'b0);
      @(negedge clk);
      check("ar_prev_zero", 16'(out_current), 16'd7);
      drive(1'b0, 8'd0, 1'b0);
      @(negedge clk);

`ifdef RNN_DECODER_STATS_EN
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("st_clr_cnt", sample_cnt, 16'd0);
      check("st_clr_wrap", 16'(wrap_flag), 16'd0);
      drive(1'b1, 8'd200, 1'b1);
      @(negedge clk);
      check("st_nowrap", 16'(wrap_flag), 16'd0);
      drive(1'b1, 8'd10, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0);
      check("st_wrap", 16'(wrap_flag), 16'd1);
      check("st_cnt2", sample_cnt, 16'd2);
      drive(1'b1, 8'd1, 1'b0);
      repeat (65540) @(posedge clk);
      @(negedge clk);
      drive(1'b0, 8'd0, 1'b0);
      check("st_saturate", sample_cnt, 16'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
